// File: rtl/lc3_pkg.sv
// lc3_pkg: shared constants for the LC-3 fetch-stage PC unit.
//   pc_sel_e     : next-PC select encodings (PCSEL_INC..PCSEL_RET; 5-7 hold)
//   LC3_RESET_VEC: default PC after reset
//   LC3_INTR_BASE: default interrupt vector table base (LC3_PC_INTR_EN builds)
package lc3_pkg;

    typedef enum logic [2:0] {
        PCSEL_INC   = 3'd0,
        PCSEL_BUS   = 3'd1,
        PCSEL_JMP   = 3'd2,
        PCSEL_CALL  = 3'd3,
        PCSEL_RET   = 3'd4,
        PCSEL_HOLD5 = 3'd5,
        PCSEL_HOLD6 = 3'd6,
        PCSEL_HOLD7 = 3'd7
    } pc_sel_e;

    localparam int unsigned LC3_RESET_VEC = 32'h0000_3000;
`ifdef LC3_PC_INTR_EN
    localparam int unsigned LC3_INTR_BASE = 32'h0000_0100;
`endif

endpackage

// File: rtl/lc3_ras.sv
// lc3_ras: ring-buffer return-address stack.
//   clk, rst  : clock, async active-high reset (pointer/count only)
//   push, pop : one operation per cycle; pop on empty is ignored
//   din       : value pushed
//   top       : most recently pushed valid entry
//   count     : valid entries, saturates at DEPTH
//   full/empty: count == DEPTH / count == 0
// A push while full writes into the slot under the pointer, which in a full
// ring is the oldest entry, so overflow simply drops the oldest address.
module lc3_ras #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               top,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);
    import lc3_pkg::*;

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] ptr;      // next slot to write
    logic [PTR_W-1:0] top_idx;

    assign top_idx = ptr - PTR_ONE;
    assign top     = mem[top_idx];
    assign full    = (count == CNT_MAX);
    assign empty   = (count == '0);

    // Storage is not reset; only pointer/count define validity.
    always_ff @(posedge clk) begin
        if (push) mem[ptr] <= din;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr   <= '0;
            count <= '0;
        end else if (push) begin
            ptr <= ptr + PTR_ONE;
            if (!full) count <= count + CNT_ONE;
        end else if (pop && !empty) begin
            ptr   <= top_idx;
            count <= count - CNT_ONE;
        end
    end

endmodule

// File: rtl/lc3_pc_unit.sv
// lc3_pc_unit: LC-3 program counter, next-PC mux and return-address stack.
//   clk, rst        : clock, async active-high reset
//   ld_pc, stall    : update when ld_pc && !stall; stall freezes PC and RAS
//   pc_sel          : 0 INC, 1 BUS, 2 JMP, 3 CALL, 4 RET, 5-7 HOLD
//   cpu_bus         : BUS target and RET-on-empty fallback (R7)
//   jmp_addr        : JMP / CALL target
//   err_clr         : clears sticky ras_ovf / ras_unf (a new error wins)
//   o_pc, o_pc_inc  : current PC and PC+1 (combinational)
//   ras_count/full/empty, ras_ovf (CALL while full), ras_unf (RET while empty)
// Build option LC3_PC_INTR_EN adds intr_req/intr_vec/intr_ack: an interrupt
// taken on an update edge beats pc_sel, jumps to INTR_BASE+intr_vec and pushes
// the current PC (not PC+1), since the interrupted instruction has not run.
module lc3_pc_unit
    import lc3_pkg::*;
#(
    parameter int                ADDR_W    = 16,
    parameter int                RAS_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC = ADDR_W'(LC3_RESET_VEC)
`ifdef LC3_PC_INTR_EN
    ,
    parameter logic [ADDR_W-1:0] INTR_BASE = ADDR_W'(LC3_INTR_BASE)
`endif
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         ld_pc,
    input  logic                         stall,
    input  logic [2:0]                   pc_sel,
    input  logic [ADDR_W-1:0]            cpu_bus,
    input  logic [ADDR_W-1:0]            jmp_addr,
    input  logic                         err_clr,
    output logic [ADDR_W-1:0]            o_pc,
    output logic [ADDR_W-1:0]            o_pc_inc,
    output logic [$clog2(RAS_DEPTH):0]   ras_count,
    output logic                         ras_full,
    output logic                         ras_empty,
    output logic                         ras_ovf,
    output logic                         ras_unf
`ifdef LC3_PC_INTR_EN
    ,
    input  logic                         intr_req,
    input  logic [7:0]                   intr_vec,
    output logic                         intr_ack
`endif
);

    logic              upd;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] push_data;
    logic [ADDR_W-1:0] ras_top;
    logic              push, pop;
    logic              ovf_set, unf_set;
`ifdef LC3_PC_INTR_EN
    logic              intr_take;
`endif

    assign upd      = ld_pc && !stall;
    assign o_pc_inc = o_pc + ADDR_W'(1);

    always_comb begin
        pc_next   = o_pc;
        push      = 1'b0;
        pop       = 1'b0;
        push_data = o_pc_inc;
        unf_set   = 1'b0;
`ifdef LC3_PC_INTR_EN
        intr_take = 1'b0;
`endif
        if (upd) begin
`ifdef LC3_PC_INTR_EN
            if (intr_req) begin
                intr_take = 1'b1;
                pc_next   = INTR_BASE + ADDR_W'(intr_vec);
                push      = 1'b1;
                push_data = o_pc;
            end else begin
`endif
            case (pc_sel)
                PCSEL_INC:  pc_next = o_pc_inc;
                PCSEL_BUS:  pc_next = cpu_bus;
                PCSEL_JMP:  pc_next = jmp_addr;
                PCSEL_CALL: begin
                    pc_next = jmp_addr;
                    push    = 1'b1;
                end
                PCSEL_RET: begin
                    if (!ras_empty) begin
                        pc_next = ras_top;
                        pop     = 1'b1;
                    end else begin
                        // Empty stack: fall back to R7 presented on the bus.
                        pc_next = cpu_bus;
                        unf_set = 1'b1;
                    end
                end
                default: pc_next = o_pc;
            endcase
`ifdef LC3_PC_INTR_EN
            end
`endif
        end
    end

    assign ovf_set = push && ras_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_pc    <= RESET_VEC;
            ras_ovf <= 1'b0;
            ras_unf <= 1'b0;
        end else begin
            o_pc <= pc_next;
            if (ovf_set)      ras_ovf <= 1'b1;
            else if (err_clr) ras_ovf <= 1'b0;
            if (unf_set)      ras_unf <= 1'b1;
            else if (err_clr) ras_unf <= 1'b0;
        end
    end

`ifdef LC3_PC_INTR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) intr_ack <= 1'b0;
        else     intr_ack <= intr_take;
    end
`endif

    lc3_ras #(
        .W     (ADDR_W),
        .DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (push_data),
        .top   (ras_top),
        .count (ras_count),
        .full  (ras_full),
        .empty (ras_empty)
    );

endmodule
